// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed multi-digit 7-segment driver with a
// double-buffered BCD value and optional leading-zero blanking.
// Optional build macro SEG7_ANTIGHOST_EN: blanks dig_en during the first
// output cycle of each digit slot so slow digit drivers cannot ghost.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF  = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] active;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              cur_nibble;
    logic [6:0]              raw_pattern;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic                    wrap;

    // Active-low segment pattern (a..g) for one BCD nibble; non-BCD codes are dark.
    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b0100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0000100;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign wrap = (cnt == CNT_LAST) && (idx == IDX_LAST);

    // Prescaler sets the slot width; the digit index steps once per slot and wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow takes every load; active only copies the old shadow at the frame wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (load) begin
                shadow <= value_in;
            end
            if (wrap) begin
                active <= shadow;
            end
        end
    end

    // Mark digits that are zero with only zeros above them; digit 0 always shows.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (active[4*i +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            lz_mask[i] = ~seen;
        end
    end

    // Select the current digit's nibble, pattern and one-hot enable.
    always_comb begin
        cur_nibble  = active[{idx, 2'b00} +: 4];
        raw_pattern = (blank_lz && lz_mask[idx]) ? 7'b1111111 : decode(cur_nibble);
        dig_sel     = (NUM_DIGITS'(1) << idx) ^ DIG_OFF;
    end

    // Register the pins one cycle behind the index; frame_start marks digit 0's first cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out     <= SEG_OFF;
            dig_en      <= DIG_OFF;
            frame_start <= 1'b0;
        end else begin
            seg_out     <= raw_pattern ^ {7{~SEG_ACTIVE_LOW}};
            frame_start <= (idx == '0) && (cnt == '0);
`ifdef SEG7_ANTIGHOST_EN
            dig_en      <= (cnt == '0) ? DIG_OFF : dig_sel;
`else
            dig_en      <= dig_sel;
`endif
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 4-cycle slots).
// Expected frames are queued when loads are driven and popped per displayed frame.
module tb_seg7_scan_driver;

    localparam int ND  = 4;
    localparam int DIV = 4;
    localparam int FRAME_LEN = ND * DIV;

    typedef struct {
        logic [15:0] val;
        bit          blz;
    } frame_t;

    logic        clk;
    logic        rst;
    logic [15:0] value_in;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg_out;
    logic [3:0]  dig_en;
    logic        frame_start;

    int          testCount;
    int          failCount;
    frame_t      expq[$];
    logic [15:0] modelShadow;
    logic [6:0]  segTable[16];

    seg7_scan_driver #(
        .NUM_DIGITS    (ND),
        .REFRESH_DIV   (DIV),
        .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .seg_out    (seg_out),
        .dig_en     (dig_en),
        .frame_start(frame_start)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it when the observed value differs
    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drive the load strobe for the coming edge and track what the shadow will hold
    task automatic applyStimulus(input bit ld, input logic [15:0] val);
        load = ld;
        if (ld) begin
            value_in    = val;
            modelShadow = val;
        end
    endtask

    // Expected active-low segment pattern for one digit of a displayed value
    function automatic logic [6:0] modelSeg(input logic [15:0] v, input bit blz, input int slot);
        logic [15:0] upper;
        logic [3:0]  nib;
        upper = v >> (4 * slot);
        nib   = upper[3:0];
        if (blz && slot > 0 && upper == 16'h0) begin
            return 7'b1111111;
        end
        return segTable[nib];
    endfunction

    // Check the reset-time pin state
    task automatic checkResetState(input string tag);
        checkOutput({tag, " seg"}, {9'h0, seg_out}, 16'h007F);
        checkOutput({tag, " dig"}, {12'h0, dig_en}, 16'h000F);
        checkOutput({tag, " fs"},  {15'h0, frame_start}, 16'h0000);
    endtask

    // Observe one full frame starting at its first output cycle, with up to two loads
    task automatic runFrame(input int frameNo, input int lp1, input logic [15:0] lv1,
                            input int lp2, input logic [15:0] lv2, input bit blzNext);
        frame_t      cur;
        int          slot;
        logic [3:0]  expDig;
        checkOutput($sformatf("f%0d sbReady", frameNo), 16'(expq.size() > 0), 16'h1);
        if (expq.size() > 0) begin
            cur = expq.pop_front();
        end else begin
            cur.val = 16'hxxxx;
            cur.blz = 1'b0;
        end
        for (int pos = 1; pos <= FRAME_LEN; pos++) begin
            slot   = (pos - 1) / DIV;
            expDig = 4'hF ^ (4'b0001 << slot);
`ifdef SEG7_ANTIGHOST_EN
            if ((pos - 1) % DIV == 0) begin
                expDig = 4'hF;
            end
`endif
            checkOutput($sformatf("f%0d p%0d fs", frameNo, pos), {15'h0, frame_start},
                        (pos == 1) ? 16'h1 : 16'h0);
            checkOutput($sformatf("f%0d p%0d dig", frameNo, pos), {12'h0, dig_en}, {12'h0, expDig});
            checkOutput($sformatf("f%0d p%0d seg", frameNo, pos), {9'h0, seg_out},
                        {9'h0, modelSeg(cur.val, cur.blz, slot)});
            if (pos == FRAME_LEN - 1) begin
                expq.push_back('{val: modelShadow, blz: blzNext});
            end
            if (pos == lp1) begin
                applyStimulus(1'b1, lv1);
            end else if (pos == lp2) begin
                applyStimulus(1'b1, lv2);
            end else begin
                applyStimulus(1'b0, 16'h0);
            end
            if (pos == FRAME_LEN) begin
                blank_lz = blzNext;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        segTable = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                     7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                     7'b0000000, 7'b0000100, 7'b1111111, 7'b1111111,
                     7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
        testCount   = 0;
        failCount   = 0;
        modelShadow = 16'h0;
        rst         = 1'b1;
        load        = 1'b0;
        value_in    = 16'h0;
        blank_lz    = 1'b0;

        @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;
        expq.push_back('{val: 16'h0000, blz: 1'b0});
        @(negedge clk);

        // frame, load pos/value, second load pos/value, blank_lz for next frame
        runFrame(0, 5,  16'h1234, 0, 16'h0,    1'b0);
        runFrame(1, 15, 16'h5678, 0, 16'h0,    1'b0);
        runFrame(2, 0,  16'h0,    0, 16'h0,    1'b1);
        runFrame(3, 2,  16'h0070, 0, 16'h0,    1'b1);
        runFrame(4, 7,  16'h0000, 0, 16'h0,    1'b1);
        runFrame(5, 4,  16'hA0F9, 0, 16'h0,    1'b1);
        runFrame(6, 3,  16'h1111, 9, 16'h2222, 1'b0);
        runFrame(7, 16, 16'h0070, 0, 16'h0,    1'b0);
        runFrame(8, 0,  16'h0,    0, 16'h0,    1'b0);
        runFrame(9, 0,  16'h0,    0, 16'h0,    1'b0);

        // Abort the scan during the digit 2 slot; display restarts at digit 0
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkResetState("midReset");
        rst = 1'b0;
        expq.delete();
        modelShadow = 16'h0;
        expq.push_back('{val: 16'h0000, blz: blank_lz});
        @(negedge clk);
        runFrame(10, 6, 16'h9087, 0, 16'h0, 1'b0);
        runFrame(11, 0, 16'h0,    0, 16'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
